pcie_h2c_frame_parser: RTL
==========================

Name: pcie_h2c_frame_parser

Overview:
- Sits between the PCIe DMA H2C AXI-Stream master (256-bit, 250 MHz user clock) and the RDM/KVS RX ingress.
- Consumes one header beat per frame and validates magic and length.
- Forwards payload beats with a regenerated tlast, and drops malformed frames whole.
- Exposes the decoded header as sideband and pulses an error code for bad frames.

Parameters:
- DATA_WIDTH, 256, AXIS data width in bits; tkeep is DATA_WIDTH/8 bits.
- MAGIC, 16'h4C45, required value of header bits [15:0].
- MAX_LEN, 32'h0010_0000, largest legal payload length in bytes.

Ports:
- clk  in  1  H2C user clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_tdata  in  DATA_WIDTH  H2C data.
- s_tkeep  in  DATA_WIDTH/8  H2C byte enables.
- s_tlast  in  1  H2C end of frame.
- s_tvalid  in  1  H2C valid.
- s_tready  out  1  H2C ready.
- m_tdata  out  DATA_WIDTH  payload data.
- m_tkeep  out  DATA_WIDTH/8  payload byte enables.
- m_tlast  out  1  regenerated end of payload.
- m_tvalid  out  1  payload valid.
- m_tready  in  1  downstream ready.
- hdr_opcode  out  8  opcode of the current frame; stable from header accept until the next header.
- hdr_len  out  32  payload byte length of the current frame; stable like hdr_opcode.
- hdr_valid  out  1  one-cycle pulse when a good header is accepted.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  1 = bad magic, 2 = length > MAX_LEN, 3 = tlast mismatch.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values: all outputs 0 except s_tready (1, since the FSM resets to HDR with the slice empty); state HDR; beat counter 0; output slice empty.
- Header layout (first beat): [15:0] magic, [23:16] opcode, [31:24] reserved, [63:32] length in bytes. Bits above 63 are ignored.
- Beat count: beats = ceil(len/32), computed as (len+31)>>5 in 33-bit arithmetic so there is no overflow.
- State HDR: s_tready=1; the beat is consumed and never forwarded.
  - Magic bad → err 1. Go to DROP, or stay in HDR if s_tlast.
  - len > MAX_LEN → err 2, handled like bad magic.
  - len==0 with s_tlast → hdr_valid pulse, stay in HDR, nothing emitted.
  - len==0 without s_tlast → hdr_valid pulse, then err 3, go to DROP.
  - Otherwise → latch the header, hdr_valid pulse, load remaining=beats, go to PAY.
- State PAY: each accepted beat enters the output slice with m_tlast=(remaining==1); remaining decrements.
  - s_tlast on a beat with remaining>1 → that beat goes out with m_tlast forced to 1, err 3, go to HDR.
  - remaining==1 and s_tlast → go to HDR.
  - remaining==1 and !s_tlast → m_tlast=1, err 3, go to DROP.
- State DROP: s_tready=1; beats are discarded until s_tlast is accepted, then go to HDR. No output.
- Output slice: 2-entry skid buffer, full throughput, 1-cycle latency from s to m.
  - In PAY, s_tready = slice not full.
  - m_tvalid is never deasserted and m_tdata never changes while m_tvalid && !m_tready.
- Each error is a one-cycle err_valid pulse. At most one error per frame.
- Back-to-back frames: a header may be accepted the cycle after the previous tlast; the slice may still hold payload at that point.
- Reset mid-frame: the slice is flushed, the FSM returns to HDR, and no error is reported.

Optional Feature:
- Macro PCIE_H2C_PARSER_STATS_EN.
- When defined: add outputs stat_frames_ok (32), stat_frames_drop (32) and stat_beats (48).
  - These are saturating counters, cleared by rst_n.
  - stat_frames_ok increments on a good frame completion; stat_frames_drop increments on each err pulse; stat_beats increments on each forwarded beat.
- When not defined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package pcie_h2c_pkg holds:
  - header field offsets;
  - err_code constants ERR_NONE, ERR_MAGIC, ERR_LEN, ERR_TLAST;
  - the state enum {HDR, PAY, DROP}.
- Sub-module axis_skid_buf (DATA_WIDTH + keep + last, 2 entries) implements the output slice.

Test Plan:
- Good frame, len=64, 2 payload beats, m_tready=1 → hdr_valid once, 2 m beats with m_tlast on the 2nd, 1-cycle latency, no err.
- Bad magic 16'h1234, 3-beat frame → err_code=1 once, 0 m beats, next good frame passes.
- len=96 but s_tlast on the 2nd payload beat → 2 beats out, 2nd with m_tlast, err_code=3.
- len=32 with 3 trailing beats → 1 beat out with m_tlast, err_code=3, remaining beats dropped, s_tready=1 throughout the drop.
- Random m_tready toggling over 10 frames of len=33..320 → data and order match the input; no beat lost or duplicated; m_tdata stable while stalled.
- rst_n low for 1 cycle mid-PAY → m_tvalid=0 the next cycle, state HDR; the following good frame parses correctly.

Source files
------------

// File: rtl/pcie_h2c_pkg.sv
// Shared definitions for the PCIe H2C frame parser: header field offsets,
// error codes, FSM state encodings and the length-to-beats helper.
package pcie_h2c_pkg;

  // Header beat field offsets (bits above the length field are ignored)
  localparam int MAGIC_LSB = 0;
  localparam int MAGIC_W   = 16;
  localparam int OPC_LSB   = 16;
  localparam int OPC_W     = 8;
  localparam int LEN_LSB   = 32;
  localparam int LEN_W     = 32;

  // err_code values
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_TLAST = 2'd3;

  // Parser states
  typedef logic [1:0] state_t;
  localparam state_t HDR  = 2'd0;
  localparam state_t PAY  = 2'd1;
  localparam state_t DROP = 2'd2;

  // ceil(len/32) evaluated in 33 bits so len near 2^32 cannot wrap
  function automatic logic [27:0] len_to_beats(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'd31;
    return sum[32:5];
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered output plus one skid slot,
// full throughput with one cycle of latency from input to output.
module axis_skid_buf #(
  parameter int WIDTH = 289
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             push;

  assign in_ready = !skid_valid;
  assign push     = in_valid && !skid_valid;

  // Occupancy: output slot refills from skid first, else from the input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
    end
  end

  // Output data register; cleared so the payload bus reads zero out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) out_data <= skid_data;
      else if (push)  out_data <= in_data;
    end
  end

  // Skid slot captures a beat only while the output is stalled
  always_ff @(posedge clk) begin
    if (push && out_valid && !out_ready) skid_data <= in_data;
  end

endmodule

// File: rtl/pcie_h2c_frame_parser.sv
// PCIe DMA H2C frame parser: consumes one header beat per frame, validates
// magic and length, forwards payload with a regenerated tlast and drops
// malformed frames whole. Optional statistics counters are enabled by
// defining PCIE_H2C_PARSER_STATS_EN.
module pcie_h2c_frame_parser
  import pcie_h2c_pkg::*;
#(
  parameter int          DATA_WIDTH = 256,
  parameter logic [15:0] MAGIC      = 16'h4C45,
  parameter logic [31:0] MAX_LEN    = 32'h0010_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [7:0]              hdr_opcode,
  output logic [31:0]             hdr_len,
  output logic                    hdr_valid,
  output logic                    err_valid,
  output logic [1:0]              err_code
`ifdef PCIE_H2C_PARSER_STATS_EN
  ,
  output logic [31:0]             stat_frames_ok,
  output logic [31:0]             stat_frames_drop,
  output logic [47:0]             stat_beats
`endif
);

  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int SLICE_W = DATA_WIDTH + KEEP_W + 1;

  state_t       state;
  logic [27:0]  remaining;
  logic         err_pend;
  logic         slice_ready;
  logic         slice_push;
  logic         slice_last;
  logic         fire;
  logic [15:0]  in_magic;
  logic [7:0]   in_opcode;
  logic [31:0]  in_len;

  assign in_magic  = s_tdata[MAGIC_LSB +: MAGIC_W];
  assign in_opcode = s_tdata[OPC_LSB +: OPC_W];
  assign in_len    = s_tdata[LEN_LSB +: LEN_W];

  assign s_tready   = (state == PAY) ? slice_ready : 1'b1;
  assign fire       = s_tvalid && s_tready;
  assign slice_push = s_tvalid && slice_ready && (state == PAY);
  // A beat closes the payload on the expected count or on an early tlast
  assign slice_last = (remaining == 28'd1) || s_tlast;

  axis_skid_buf #(.WIDTH(SLICE_W)) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s_tdata, s_tkeep, slice_last}),
    .in_valid  (slice_push),
    .in_ready  (slice_ready),
    .out_data  ({m_tdata, m_tkeep, m_tlast}),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

  // Frame FSM with registered header sideband and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HDR;
      remaining  <= '0;
      err_pend   <= 1'b0;
      hdr_valid  <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      hdr_opcode <= '0;
      hdr_len    <= '0;
    end else begin
      // A zero-length header without tlast reports its error one cycle
      // after the hdr_valid pulse; the FSM is in DROP then, so no clash.
      hdr_valid <= 1'b0;
      err_valid <= err_pend;
      err_code  <= err_pend ? ERR_TLAST : ERR_NONE;
      err_pend  <= 1'b0;
      if (fire) begin
        case (state)
          HDR: begin
            if (in_magic != MAGIC) begin
              err_valid <= 1'b1;
              err_code  <= ERR_MAGIC;
              state     <= s_tlast ? HDR : DROP;
            end else if (in_len > MAX_LEN) begin
              err_valid <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= s_tlast ? HDR : DROP;
            end else begin
              hdr_valid  <= 1'b1;
              hdr_opcode <= in_opcode;
              hdr_len    <= in_len;
              if (in_len == 32'd0) begin
                if (!s_tlast) begin
                  err_pend <= 1'b1;
                  state    <= DROP;
                end
              end else begin
                remaining <= len_to_beats(in_len);
                state     <= PAY;
              end
            end
          end
          PAY: begin
            if (remaining == 28'd1) begin
              if (s_tlast) begin
                state <= HDR;
              end else begin
                err_valid <= 1'b1;
                err_code  <= ERR_TLAST;
                state     <= DROP;
              end
            end else if (s_tlast) begin
              err_valid <= 1'b1;
              err_code  <= ERR_TLAST;
              state     <= HDR;
            end else begin
              remaining <= remaining - 28'd1;
            end
          end
          DROP: begin
            if (s_tlast) state <= HDR;
          end
          default: state <= HDR;
        endcase
      end
    end
  end

`ifdef PCIE_H2C_PARSER_STATS_EN
  logic good_done;

  assign good_done = fire && s_tlast &&
                     (((state == PAY) && (remaining == 28'd1)) ||
                      ((state == HDR) && (in_magic == MAGIC) && (in_len == 32'd0)));

  // Saturating frame/beat statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames_ok   <= '0;
      stat_frames_drop <= '0;
      stat_beats       <= '0;
    end else begin
      if (good_done && (stat_frames_ok != '1))    stat_frames_ok   <= stat_frames_ok + 32'd1;
      if (err_valid && (stat_frames_drop != '1))  stat_frames_drop <= stat_frames_drop + 32'd1;
      if (m_tvalid && m_tready && (stat_beats != '1)) stat_beats   <= stat_beats + 48'd1;
    end
  end
`endif

endmodule
